tlp_tx_arbiter: RTL and testbench
=================================

Name: tlp_tx_arbiter

Overview:
- Transmit-side scheduler for the PCIe transaction layer.
- Shares one TX TLP stream between three requesters: posted (P), non-posted (NP) and completion (CPL).
- Classifies each request from its Fmt/Type header fields and gates it on flow-control credits.
- Sequences the granted TLP beat by beat onto the link-layer interface.

Parameters:
- P_HDR_CRED, 8, initial posted header credits.
- P_DATA_CRED, 64, initial posted data credits (1 credit = 4 DW).
- NP_HDR_CRED, 8, initial non-posted header credits.
- CPL_HDR_CRED, 8, initial completion header credits.
- CPL_DATA_CRED, 64, initial completion data credits.
- CRED_W, 8, width of each credit counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  3  per-requester request valid; bit0=P, bit1=NP, bit2=CPL
- req_fmt  in  9  3-bit Fmt per requester, packed {cpl,np,p}
- req_type  in  15  5-bit Type per requester, packed {cpl,np,p}
- req_len  in  30  10-bit length in DW per requester; 0 encodes 1024
- req_ready  out  3  one-hot: request accepted this cycle
- beat_ready  out  3  one-hot: requester may advance to its next beat
- tx_valid  out  1  beat valid toward link layer
- tx_ready  in  1  link layer accepts beat
- tx_sel  out  2  owning requester of the current beat (0=P, 1=NP, 2=CPL)
- tx_sop  out  1  header beat
- tx_eop  out  1  last beat
- cred_ret_valid  in  1  credit return strobe
- cred_ret_class  in  2  0=P, 1=NP, 2=CPL
- cred_ret_hdr  in  1  returns one header credit
- cred_ret_data  in  CRED_W  data credits returned
- illegal_req  out  1  one-cycle pulse: request dropped as unsupported/mismatched class

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values:
  - Credit counters load their parameters.
  - State=IDLE; rr_ptr=0.
  - All outputs 0.
- Classification:
  - has_data = fmt[1].
  - Mem/IO/Cfg write → P if MWr (type 00000), NP otherwise.
  - MRd/IORd/CfgRd → NP.
  - Msg (type[4]=1) → P.
  - Cpl/CplD (type 01010) → CPL.
  - Any other encoding, or a class that differs from the channel's class: assert illegal_req for 1 cycle and req_ready for that channel (drop).
- Data credits needed = ceil(len/4) when has_data, else 0.
- Eligibility: req_valid && hdr_cred>=1 && data_cred>=needed.
  - NP has no data-credit check; NP writes are IO/Cfg with 1 DW.
- FSM:
  - IDLE: if any request is eligible → ARB.
  - ARB (1 cycle):
    - Round-robin pick starting at rr_ptr.
    - Pulse req_ready; debit credits in the same cycle.
    - Latch beats = 1 + (has_data ? len : 0).
    - rr_ptr = winner+1 mod 3.
    - → XFER.
  - XFER: tx_valid=1, tx_sel=winner. On tx_valid&&tx_ready:
    - Beat count decrements and beat_ready[winner] pulses.
    - tx_sop=1 on the first beat only; tx_eop=1 when the count equals 1.
    - The eop handshake → IDLE.
- Grant latency: request to first tx_valid = 2 cycles (IDLE→ARB→XFER).
- tx_valid holds while tx_ready is low; no beat is dropped.
- Credit return:
  - Counters saturate at all-ones.
  - A return coinciding with a debit of the same class applies both (net result).
- Credits at 0: the request waits indefinitely. No timeout. Other classes are not blocked.
- Ordering:
  - CPL and NP never overtake an older pending P of the same cycle's snapshot only if the P is eligible.
  - An ineligible P never blocks NP/CPL (deadlock avoidance).
- Reset mid-XFER aborts immediately; outputs go to reset values and credits reload.

Optional Feature:
- Macro: POSTED_STRICT_PRIO_EN.
- Defined: an eligible P always wins ARB; rr_ptr is used only among NP/CPL.
- Undefined: pure 3-way round-robin as above.

Decomposition:
- Shared package tlp_pkg holds:
  - FMT/TYPE localparams: MRD, MRDLK, IORD/IOWR, CFG0, MSG, CPL.
  - Class encodings P/NP/CPL.
  - Function tlp_classify(fmt, type) returning {class, has_data, legal}.
- Natural sub-module: tlp_credit_counter, one instance per class, covering hdr+data debit/return/saturate.

Test Plan:
- Reset:
  - After rst_n release, P_HDR=8 and P_DATA=64.
  - Single P MWr with fmt=010, type=00000, len=8 → tx_valid at cycle+2.
  - 9 beats; sop on beat 1, eop on beat 9.
  - P_DATA drops to 62 and P_HDR to 7.
- Round-robin:
  - All three channels request legal zero-data TLPs continuously (P=MsgNoData, NP=MRd, CPL=Cpl).
  - Grant order is P, NP, CPL, P.
- Credit starvation:
  - Set P_DATA=1 via params; P MWr len=16 (needs 4) plus NP MRd.
  - NP is granted; P waits.
  - cred_ret P data=3 → P granted next arbitration.
- Backpressure:
  - Hold tx_ready low for 5 cycles mid-TLP.
  - tx_valid stays high and tx_sel is stable; beat count is unchanged.
- Illegal request:
  - P channel sends fmt=000, type=01010 (Cpl on P) → illegal_req pulses once and req_ready[0]=1.
  - Nothing is transmitted.
- POSTED_STRICT_PRIO_EN:
  - With P and NP continuously eligible, every grant goes to P.
  - Without the macro, grants alternate P/NP.

Source files
------------

// File: rtl/tlp_pkg.sv
// Shared definitions for the TLP transmit arbiter.
//   - Fmt/Type encodings that the classifier recognises
//   - Traffic class encodings (P / NP / CPL), used as requester indices
//   - Arbiter FSM state type
//   - tlp_classify(): maps a Fmt/Type pair to {class, has_data, legal}
//   - rr_next(): modulo-3 successor used by the round-robin pointer
package tlp_pkg;

    // Traffic classes; also the requester/channel index.
    localparam logic [1:0] CLS_P   = 2'd0;
    localparam logic [1:0] CLS_NP  = 2'd1;
    localparam logic [1:0] CLS_CPL = 2'd2;

    // Fmt field: bit1 = has data, bit0 = 4DW header, bit2 = TLP prefix.
    localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
    localparam logic [2:0] FMT_4DW_NODATA = 3'b001;
    localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
    localparam logic [2:0] FMT_4DW_DATA   = 3'b011;

    // Type field encodings.
    localparam logic [4:0] TYPE_MRD   = 5'b00000;  // MRd / MWr
    localparam logic [4:0] TYPE_MRDLK = 5'b00001;
    localparam logic [4:0] TYPE_IO    = 5'b00010;  // IORd / IOWr
    localparam logic [4:0] TYPE_CFG0  = 5'b00100;
    localparam logic [4:0] TYPE_CFG1  = 5'b00101;
    localparam logic [4:0] TYPE_MSG   = 5'b10000;  // any type with bit4 set
    localparam logic [4:0] TYPE_CPL   = 5'b01010;  // Cpl / CplD

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_XFER = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [1:0] cls;
        logic       has_data;
        logic       legal;
    } tlp_class_t;

    function automatic tlp_class_t tlp_classify(input logic [2:0] fmt,
                                                input logic [4:0] typ);
        tlp_class_t r;
        r.cls      = CLS_P;
        r.has_data = fmt[1];
        r.legal    = 1'b0;
        if (fmt[2]) begin
            // TLP prefixes are not supported on this path.
            r.legal = 1'b0;
        end else if (typ[4]) begin
            r.cls   = CLS_P;
            r.legal = 1'b1;
        end else begin
            case (typ)
                TYPE_MRD: begin
                    r.cls   = fmt[1] ? CLS_P : CLS_NP;
                    r.legal = 1'b1;
                end
                TYPE_MRDLK: begin
                    r.cls   = CLS_NP;
                    r.legal = !fmt[1];
                end
                TYPE_IO, TYPE_CFG0, TYPE_CFG1: begin
                    // IO and config requests only exist with a 3DW header.
                    r.cls   = CLS_NP;
                    r.legal = !fmt[0];
                end
                TYPE_CPL: begin
                    r.cls   = CLS_CPL;
                    r.legal = !fmt[0];
                end
                default: r.legal = 1'b0;
            endcase
        end
        return r;
    endfunction

    function automatic logic [1:0] rr_next(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

endpackage

// File: rtl/tlp_credit_counter.sv
// Header + data flow-control credit pair for one traffic class.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (loads *_INIT)
//   debit            consume one header credit and debit_data data credits
//   debit_data       data credits consumed with the debit
//   ret_valid        credit return strobe for this class
//   ret_hdr          return one header credit
//   ret_data         data credits returned
//   hdr_cred         current header credits
//   data_cred        current data credits
// A debit and a return in the same cycle are both applied; results
// saturate at all-ones.
module tlp_credit_counter #(
    parameter int CRED_W    = 8,
    parameter int HDR_INIT  = 8,
    parameter int DATA_INIT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              debit,
    input  logic [CRED_W-1:0] debit_data,
    input  logic              ret_valid,
    input  logic              ret_hdr,
    input  logic [CRED_W-1:0] ret_data,
    output logic [CRED_W-1:0] hdr_cred,
    output logic [CRED_W-1:0] data_cred
);

    localparam logic [CRED_W-1:0] SAT = '1;

    // One extra bit catches overflow. The arbiter only debits what it has
    // checked is available, so the subtraction never goes negative.
    logic [CRED_W:0] hdr_sum;
    logic [CRED_W:0] data_sum;

    always_comb begin
        hdr_sum  = {1'b0, hdr_cred}
                 + {{CRED_W{1'b0}}, (ret_valid & ret_hdr)}
                 - {{CRED_W{1'b0}}, debit};
        data_sum = {1'b0, data_cred}
                 + (ret_valid ? {1'b0, ret_data} : '0)
                 - (debit ? {1'b0, debit_data} : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_cred  <= CRED_W'(HDR_INIT);
            data_cred <= CRED_W'(DATA_INIT);
        end else begin
            hdr_cred  <= hdr_sum[CRED_W]  ? SAT : hdr_sum[CRED_W-1:0];
            data_cred <= data_sum[CRED_W] ? SAT : data_sum[CRED_W-1:0];
        end
    end

endmodule

// File: rtl/tlp_tx_arbiter.sv
// PCIe transaction-layer TX scheduler: shares one TLP stream between the
// posted (0), non-posted (1) and completion (2) requesters.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid[3]               per-requester request valid
//   req_fmt[9], req_type[15]   per-requester Fmt/Type, packed {cpl,np,p}
//   req_len[30]                per-requester length in DW, 0 means 1024
//   req_ready[3]               one-hot: request accepted (or dropped) now
//   beat_ready[3]              one-hot: owner may present its next beat
//   tx_valid/tx_ready          beat handshake toward the link layer
//   tx_sel, tx_sop, tx_eop     beat owner, header beat, last beat
//   cred_ret_*                 flow-control credit return
//   illegal_req                one-cycle pulse when a request is dropped
// Handshakes: a request is consumed in the cycle req_ready[i] is high; a
// beat is consumed on a clock edge where tx_valid && tx_ready, and then
// beat_ready[owner] is high in that same cycle. tx_valid never drops
// while waiting for tx_ready.
// Build option: define POSTED_STRICT_PRIO_EN to give an eligible posted
// request absolute priority; the round-robin pointer then only arbitrates
// between NP and CPL. Undefined: plain 3-way round-robin.
// The FSM state is the `state` signal of this module.
module tlp_tx_arbiter
    import tlp_pkg::*;
#(
    parameter int P_HDR_CRED    = 8,
    parameter int P_DATA_CRED   = 64,
    parameter int NP_HDR_CRED   = 8,
    parameter int CPL_HDR_CRED  = 8,
    parameter int CPL_DATA_CRED = 64,
    parameter int CRED_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        req_valid,
    input  logic [8:0]        req_fmt,
    input  logic [14:0]       req_type,
    input  logic [29:0]       req_len,
    output logic [2:0]        req_ready,
    output logic [2:0]        beat_ready,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [1:0]        tx_sel,
    output logic              tx_sop,
    output logic              tx_eop,
    input  logic              cred_ret_valid,
    input  logic [1:0]        cred_ret_class,
    input  logic              cred_ret_hdr,
    input  logic [CRED_W-1:0] cred_ret_data,
    output logic              illegal_req
);

    arb_state_t state, state_nxt;
    logic [1:0]  rr_ptr, rr_ptr_nxt;
    logic [1:0]  win_q, win_nxt;
    logic [10:0] beats_q, beats_nxt;
    logic        first_q, first_nxt;

    tlp_class_t        cls_info  [3];
    logic [10:0]       len_dw    [3];
    logic [11:0]       need      [3];   // data credits needed (max 256)
    logic [CRED_W-1:0] hdr_cred  [3];
    logic [CRED_W-1:0] data_cred [3];
    logic [2:0]        elig;
    logic [2:0]        illegal;
    logic [2:0]        debit;
    logic [2:0]        ret_hit;

    logic       pick_found;
    logic [1:0] pick;
    logic [1:0] cand;
    logic       ill_found;
    logic [1:0] ill_pick;

    // ---------------- classification and eligibility ----------------
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cls_info[i] = tlp_classify(req_fmt[3*i +: 3], req_type[5*i +: 5]);
            len_dw[i]   = (req_len[10*i +: 10] == 10'd0) ? 11'd1024
                                                         : {1'b0, req_len[10*i +: 10]};
            // ceil(len/4) in 4-DW credits
            need[i]     = cls_info[i].has_data
                        ? {3'b000, len_dw[i][10:2]} + {11'd0, |len_dw[i][1:0]}
                        : 12'd0;
            illegal[i]  = req_valid[i] && (!cls_info[i].legal || cls_info[i].cls != 2'(i));
            // NP writes are single-DW IO/Cfg and carry no data-credit check.
            elig[i]     = req_valid[i] && cls_info[i].legal && (cls_info[i].cls == 2'(i))
                        && (hdr_cred[i] != '0)
                        && ((cls_info[i].cls == CLS_NP) || (12'(data_cred[i]) >= need[i]));
        end
    end

    // ---------------- winner selection ----------------
    always_comb begin
        pick_found = 1'b0;
        pick       = 2'd0;
        cand       = rr_ptr;
`ifdef POSTED_STRICT_PRIO_EN
        if (elig[CLS_P]) begin
            pick_found = 1'b1;
            pick       = CLS_P;
        end
`endif
        // Scan rr_ptr, rr_ptr+1, rr_ptr+2; ineligible channels are skipped
        // so a credit-starved class never blocks the others.
        for (int k = 0; k < 3; k++) begin
            if (!pick_found && elig[cand]) begin
                pick_found = 1'b1;
                pick       = cand;
            end
            cand = rr_next(cand);
        end

        ill_found = 1'b0;
        ill_pick  = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (illegal[i]) begin
                ill_found = 1'b1;
                ill_pick  = 2'(i);
            end
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            rr_ptr  <= 2'd0;
            win_q   <= 2'd0;
            beats_q <= 11'd0;
            first_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            rr_ptr  <= rr_ptr_nxt;
            win_q   <= win_nxt;
            beats_q <= beats_nxt;
            first_q <= first_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rr_ptr_nxt  = rr_ptr;
        win_nxt     = win_q;
        beats_nxt   = beats_q;
        first_nxt   = first_q;
        req_ready   = 3'b000;
        beat_ready  = 3'b000;
        debit       = 3'b000;
        tx_valid    = 1'b0;
        tx_sel      = 2'd0;
        tx_sop      = 1'b0;
        tx_eop      = 1'b0;
        illegal_req = 1'b0;

        case (state)
            S_IDLE: begin
                if ((|elig) || (|illegal)) state_nxt = S_ARB;
            end
            S_ARB: begin
                state_nxt = S_IDLE;
                // Malformed requests are flushed before anything is granted
                // so they cannot sit in front of a requester forever.
                if (ill_found) begin
                    illegal_req         = 1'b1;
                    req_ready[ill_pick] = 1'b1;
                end else if (pick_found) begin
                    req_ready[pick] = 1'b1;
                    debit[pick]     = 1'b1;
                    win_nxt         = pick;
                    beats_nxt       = 11'd1 + (cls_info[pick].has_data ? len_dw[pick] : 11'd0);
                    first_nxt       = 1'b1;
                    rr_ptr_nxt      = rr_next(pick);
                    state_nxt       = S_XFER;
                end
            end
            S_XFER: begin
                tx_valid = 1'b1;
                tx_sel   = win_q;
                tx_sop   = first_q;
                tx_eop   = (beats_q == 11'd1);
                if (tx_ready) begin
                    beat_ready[win_q] = 1'b1;
                    beats_nxt         = beats_q - 11'd1;
                    first_nxt         = 1'b0;
                    if (beats_q == 11'd1) state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- credit counters ----------------
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            ret_hit[i] = cred_ret_valid && (cred_ret_class == 2'(i));
        end
    end

    tlp_credit_counter #(
        .CRED_W(CRED_W), .HDR_INIT(P_HDR_CRED), .DATA_INIT(P_DATA_CRED)
    ) u_cred_p (
        .clk(clk), .rst_n(rst_n),
        .debit(debit[0]), .debit_data(CRED_W'(need[0])),
        .ret_valid(ret_hit[0]), .ret_hdr(cred_ret_hdr), .ret_data(cred_ret_data),
        .hdr_cred(hdr_cred[0]), .data_cred(data_cred[0])
    );

    // NP data is never debited; its data counter only tracks returns.
    tlp_credit_counter #(
        .CRED_W(CRED_W), .HDR_INIT(NP_HDR_CRED), .DATA_INIT(0)
    ) u_cred_np (
        .clk(clk), .rst_n(rst_n),
        .debit(debit[1]), .debit_data('0),
        .ret_valid(ret_hit[1]), .ret_hdr(cred_ret_hdr), .ret_data(cred_ret_data),
        .hdr_cred(hdr_cred[1]), .data_cred(data_cred[1])
    );

    tlp_credit_counter #(
        .CRED_W(CRED_W), .HDR_INIT(CPL_HDR_CRED), .DATA_INIT(CPL_DATA_CRED)
    ) u_cred_cpl (
        .clk(clk), .rst_n(rst_n),
        .debit(debit[2]), .debit_data(CRED_W'(need[2])),
        .ret_valid(ret_hit[2]), .ret_hdr(cred_ret_hdr), .ret_data(cred_ret_data),
        .hdr_cred(hdr_cred[2]), .data_cred(data_cred[2])
    );

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Directed bench for tlp_tx_arbiter. Inputs change 1ns after the rising
// edge, outputs are sampled on the falling edge.
module tb_tlp_tx_arbiter;
    import tlp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [8:0]  req_fmt = '0;
    logic [14:0] req_type = '0;
    logic [29:0] req_len = '0;
    logic        tx_ready = 1'b1;
    logic        cred_ret_valid = 1'b0;
    logic [1:0]  cred_ret_class = '0;
    logic        cred_ret_hdr = 1'b0;
    logic [7:0]  cred_ret_data = '0;
    logic [2:0]  req_ready;
    logic [2:0]  beat_ready;
    logic        tx_valid;
    logic [1:0]  tx_sel;
    logic        tx_sop;
    logic        tx_eop;
    logic        illegal_req;

    int errors = 0;
    int checks = 0;

    tlp_tx_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_fmt(req_fmt), .req_type(req_type), .req_len(req_len),
        .req_ready(req_ready), .beat_ready(beat_ready),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_sel(tx_sel),
        .tx_sop(tx_sop), .tx_eop(tx_eop),
        .cred_ret_valid(cred_ret_valid), .cred_ret_class(cred_ret_class),
        .cred_ret_hdr(cred_ret_hdr), .cred_ret_data(cred_ret_data),
        .illegal_req(illegal_req)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n          = 1'b0;
        req_valid      = '0;
        tx_ready       = 1'b1;
        cred_ret_valid = 1'b0;
        cred_ret_hdr   = 1'b0;
        cred_ret_data  = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- drivers ----------------
    task automatic set_req(input int ch, input logic [2:0] f, input logic [4:0] t,
                           input logic [9:0] l, input logic v);
        req_fmt[ch*3 +: 3]  = f;
        req_type[ch*5 +: 5] = t;
        req_len[ch*10 +: 10] = l;
        req_valid[ch]       = v;
    endtask

    // Wait for req_ready[ch]; withdraw the request after the accepting edge.
    task automatic wait_accept(input int ch, output logic hit);
        hit = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready[ch]) begin
                hit = 1'b1;
                break;
            end
        end
        if (hit) begin
            step;
            req_valid[ch] = 1'b0;
        end
    endtask

    // Wait for the eop handshake; returns just after it completes.
    task automatic wait_eop(input int budget, output logic hit);
        hit = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (tx_valid && tx_ready && tx_eop) begin
                hit = 1'b1;
                break;
            end
        end
        if (hit) step;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        do_reset;
        @(negedge clk);
        checks++;
        if ({tx_valid, tx_sop, tx_eop, illegal_req, req_ready, beat_ready, tx_sel} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0",
                     {tx_valid, tx_sop, tx_eop, illegal_req, req_ready, beat_ready, tx_sel});
        end
        checks++;
        if (dut.u_cred_p.hdr_cred !== 8'd8) begin
            errors++;
            $display("FAIL reset_p_hdr: got %0d want 8", dut.u_cred_p.hdr_cred);
        end
        checks++;
        if (dut.u_cred_p.data_cred !== 8'd64) begin
            errors++;
            $display("FAIL reset_p_data: got %0d want 64", dut.u_cred_p.data_cred);
        end
        checks++;
        if (dut.state !== S_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d want %0d", dut.state, S_IDLE);
        end
    endtask

    task automatic test_single_mwr;
        logic [7:0] got_v, exp_v;
        step;
        set_req(0, 3'b010, 5'b00000, 10'd8, 1'b1);
        @(negedge clk);
        checks++;
        if ({tx_valid, req_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL mwr_idle: got %b want 0000", {tx_valid, req_ready});
        end
        @(negedge clk);
        checks++;
        if ({tx_valid, req_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL mwr_arb: got %b want 0001", {tx_valid, req_ready});
        end
        step;
        req_valid[0] = 1'b0;
        for (int b = 1; b <= 9; b++) begin
            @(negedge clk);
            got_v = {tx_valid, tx_sop, tx_eop, beat_ready, tx_sel};
            exp_v = {1'b1, (b == 1), (b == 9), 3'b001, 2'b00};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL mwr_beat%0d: got %b want %b", b, got_v, exp_v);
            end
            step;
        end
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL mwr_done: tx_valid got %b want 0", tx_valid);
        end
        checks++;
        if (dut.u_cred_p.hdr_cred !== 8'd7) begin
            errors++;
            $display("FAIL mwr_p_hdr: got %0d want 7", dut.u_cred_p.hdr_cred);
        end
        checks++;
        if (dut.u_cred_p.data_cred !== 8'd62) begin
            errors++;
            $display("FAIL mwr_p_data: got %0d want 62", dut.u_cred_p.data_cred);
        end
    endtask

    task automatic collect_grants(output logic [1:0] got [4], output int n);
        n = 0;
        for (int i = 0; i < 4; i++) got[i] = 2'b11;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (tx_valid && tx_sop) begin
                got[n] = tx_sel;
                n++;
            end
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] got [4];
        logic [1:0] exp_s [4];
        int n;
        exp_s = '{2'd0, 2'd1, 2'd2, 2'd0};
        do_reset;
        step;
        set_req(0, 3'b000, 5'b10000, 10'd0, 1'b1);  // MsgNoData
        set_req(1, 3'b000, 5'b00000, 10'd1, 1'b1);  // MRd
        set_req(2, 3'b000, 5'b01010, 10'd1, 1'b1);  // Cpl
        collect_grants(got, n);
        req_valid = '0;
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL rr_count: got %0d grants want 4", n);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== exp_s[i]) begin
                errors++;
                $display("FAIL rr_grant%0d: got %0d want %0d", i, got[i], exp_s[i]);
            end
        end
    endtask

    task automatic test_credit_starve;
        logic hit;
        logic drop_np;
        int   p_acc;
        logic [1:0] first_sel;
        do_reset;
        step;
        // Consume 63 of the 64 posted data credits.
        set_req(0, 3'b010, 5'b00000, 10'd252, 1'b1);
        wait_accept(0, hit);
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL starve_fill_accept: got 0 want 1");
        end
        wait_eop(400, hit);
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL starve_fill_eop: got 0 want 1");
        end
        checks++;
        if (dut.u_cred_p.data_cred !== 8'd1) begin
            errors++;
            $display("FAIL starve_p_data1: got %0d want 1", dut.u_cred_p.data_cred);
        end
        set_req(0, 3'b010, 5'b00000, 10'd16, 1'b1);  // needs 4 credits
        set_req(1, 3'b000, 5'b00000, 10'd1, 1'b1);
        p_acc     = 0;
        first_sel = 2'b11;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (req_ready[0]) p_acc++;
            if (tx_valid && tx_sop && first_sel == 2'b11) first_sel = tx_sel;
            drop_np = req_ready[1];
            step;
            if (drop_np) req_valid[1] = 1'b0;
        end
        checks++;
        if (first_sel !== 2'd1) begin
            errors++;
            $display("FAIL starve_np_first: got %0d want 1", first_sel);
        end
        checks++;
        if (p_acc !== 0) begin
            errors++;
            $display("FAIL starve_p_waits: got %0d accepts want 0", p_acc);
        end
        cred_ret_valid = 1'b1;
        cred_ret_class = 2'd0;
        cred_ret_hdr   = 1'b0;
        cred_ret_data  = 8'd3;
        step;
        cred_ret_valid = 1'b0;
        cred_ret_data  = 8'd0;
        @(negedge clk);
        checks++;
        if (dut.u_cred_p.data_cred !== 8'd4) begin
            errors++;
            $display("FAIL starve_p_data4: got %0d want 4", dut.u_cred_p.data_cred);
        end
        wait_accept(0, hit);
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL starve_p_accept: got 0 want 1");
        end
        @(negedge clk);
        checks++;
        if ({tx_valid, tx_sop, tx_sel} !== 4'b1100) begin
            errors++;
            $display("FAIL starve_p_sop: got %b want 1100", {tx_valid, tx_sop, tx_sel});
        end
        checks++;
        if ({dut.u_cred_p.hdr_cred, dut.u_cred_p.data_cred} !== {8'd6, 8'd0}) begin
            errors++;
            $display("FAIL starve_p_debit: got hdr %0d data %0d want hdr 6 data 0",
                     dut.u_cred_p.hdr_cred, dut.u_cred_p.data_cred);
        end
        wait_eop(40, hit);
    endtask

    task automatic test_backpressure;
        logic hit;
        logic eop_seen;
        int   cnt;
        do_reset;
        step;
        set_req(0, 3'b010, 5'b00000, 10'd4, 1'b1);  // 5 beats
        wait_accept(0, hit);
        @(negedge clk);
        checks++;
        if ({hit, tx_valid, tx_sop} !== 3'b111) begin
            errors++;
            $display("FAIL bp_start: got %b want 111", {hit, tx_valid, tx_sop});
        end
        step;   // beat 1 taken
        step;   // beat 2 taken
        tx_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({tx_valid, tx_sel, beat_ready, tx_sop, tx_eop} !== 8'b1000_0000) begin
                errors++;
                $display("FAIL bp_stall%0d: got %b want 10000000", c,
                         {tx_valid, tx_sel, beat_ready, tx_sop, tx_eop});
            end
            step;
        end
        tx_ready = 1'b1;
        cnt      = 0;
        eop_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) begin
                cnt++;
                if (tx_eop) begin
                    eop_seen = 1'b1;
                    break;
                end
            end
            step;
        end
        step;
        checks++;
        if (cnt !== 3 || !eop_seen) begin
            errors++;
            $display("FAIL bp_remaining: got %0d beats eop %0b want 3 beats eop 1", cnt, eop_seen);
        end
    endtask

    task automatic test_illegal;
        int   ill_cnt, rdy_cnt, tx_cnt;
        logic drop;
        do_reset;
        step;
        set_req(0, 3'b000, 5'b01010, 10'd0, 1'b1);  // Cpl presented on P channel
        ill_cnt = 0;
        rdy_cnt = 0;
        tx_cnt  = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (illegal_req) ill_cnt++;
            if (req_ready[0]) rdy_cnt++;
            if (tx_valid) tx_cnt++;
            drop = req_ready[0];
            step;
            if (drop) req_valid[0] = 1'b0;
        end
        checks++;
        if (ill_cnt !== 1) begin
            errors++;
            $display("FAIL illegal_pulse: got %0d want 1", ill_cnt);
        end
        checks++;
        if (rdy_cnt !== 1) begin
            errors++;
            $display("FAIL illegal_ready: got %0d want 1", rdy_cnt);
        end
        checks++;
        if (tx_cnt !== 0) begin
            errors++;
            $display("FAIL illegal_no_tx: got %0d want 0", tx_cnt);
        end
        checks++;
        if (dut.u_cred_p.hdr_cred !== 8'd8) begin
            errors++;
            $display("FAIL illegal_no_debit: got %0d want 8", dut.u_cred_p.hdr_cred);
        end
    endtask

    task automatic test_posted_prio;
        logic [1:0] got [4];
        logic [1:0] exp_s [4];
        int n;
`ifdef POSTED_STRICT_PRIO_EN
        exp_s = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
        exp_s = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
        do_reset;
        step;
        set_req(0, 3'b000, 5'b10000, 10'd0, 1'b1);
        set_req(1, 3'b000, 5'b00000, 10'd1, 1'b1);
        collect_grants(got, n);
        req_valid = '0;
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL prio_count: got %0d grants want 4", n);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== exp_s[i]) begin
                errors++;
                $display("FAIL prio_grant%0d: got %0d want %0d", i, got[i], exp_s[i]);
            end
        end
    endtask

    task automatic test_reset_mid_xfer;
        logic hit;
        do_reset;
        step;
        set_req(0, 3'b010, 5'b00000, 10'd8, 1'b1);
        wait_accept(0, hit);
        @(negedge clk);
        checks++;
        if ({hit, tx_valid} !== 2'b11) begin
            errors++;
            $display("FAIL midrst_premise: got %b want 11", {hit, tx_valid});
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_valid, tx_sop, tx_eop, beat_ready, tx_sel} !== 8'd0) begin
            errors++;
            $display("FAIL midrst_outputs: got %b want 0",
                     {tx_valid, tx_sop, tx_eop, beat_ready, tx_sel});
        end
        checks++;
        if ({dut.u_cred_p.hdr_cred, dut.u_cred_p.data_cred} !== {8'd8, 8'd64}) begin
            errors++;
            $display("FAIL midrst_credits: got hdr %0d data %0d want hdr 8 data 64",
                     dut.u_cred_p.hdr_cred, dut.u_cred_p.data_cred);
        end
        step;
        rst_n = 1'b1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset;
        test_single_mwr;
        test_round_robin;
        test_credit_starve;
        test_backpressure;
        test_illegal;
        test_posted_prio;
        test_reset_mid_xfer;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
